// File: rtl/lcd_bus_driver_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg: state encoding, counter width and HD44780 instruction constants.
// Revision 1.0
// ============================================================================
package lcd_pkg;

  localparam int CNT_W    = 20;
  localparam int INIT_LEN = 6;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    WAIT   = 3'd4
`ifdef LCD_INIT_SEQ_EN
    ,
    PWRUP  = 3'd5,
    INIT   = 3'd6
`endif
  } state_t;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CLEAR) || (data[7:1] == 7'b0000001));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_driver_if.sv
`default_nettype none
// ============================================================================
// lcd_bus_driver_if: command handshake between software register and driver.
// Revision 1.0
// ============================================================================
interface lcd_bus_driver_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       busy;

  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_data,
    input  cmd_ready,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_data,
    output cmd_ready,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/lcd_bus_driver_init_rom.sv
`default_nettype none
// ============================================================================
// lcd_init_rom: power-on instruction sequence for the HD44780 (index -> byte).
// Revision 1.0
// ============================================================================
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] instr
);

  always_comb begin
    instr = 8'h00;
    case (idx)
      3'd0, 3'd1, 3'd2: instr = LCD_FUNC_SET;
      3'd3:             instr = LCD_DISP_ON;
      3'd4:             instr = LCD_CLEAR;
      3'd5:             instr = LCD_ENTRY;
      default:          instr = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_driver.sv
`default_nettype none
// ============================================================================
// lcd_bus_driver: HD44780 write timing engine (setup/enable/hold/exec wait).
// Optional power-on init sequence when LCD_INIT_SEQ_EN is defined. Revision 1.0
// ============================================================================
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = 3,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000
`ifdef LCD_INIT_SEQ_EN
  ,
  parameter int POWERUP_CYC   = 750000
`endif
)
(
  input  logic               clk,
  input  logic               reset_n,
  lcd_bus_driver_if.slave    cmd,
  input  logic               cfg_on,
  output logic [7:0]         lcd_data,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en,
  output logic               lcd_on
);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

`ifdef LCD_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] PWRUP_LD  = CNT_W'(POWERUP_CYC - 1);
  localparam logic             READY_RST = 1'b0;
`else
  localparam logic             READY_RST = 1'b1;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cnt_last;
  logic             en_r, en_n;
  logic             ready_r, ready_n;
  logic [7:0]       data_r, data_n;
  logic             rs_r, rs_n;
  logic             on_r;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0] init_idx, init_idx_n;
  logic       init_done, init_done_n;
  logic [7:0] rom_instr;

  lcd_init_rom u_init_rom (
    .idx   (init_idx),
    .instr (rom_instr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_idx  <= 3'd0;
      init_done <= 1'b0;
    end else begin
      init_idx  <= init_idx_n;
      init_done <= init_done_n;
    end
  end
`endif

  assign cnt_last = (cnt == '0);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt_last ? cnt : cnt - CNT_W'(1);
    en_n     = en_r;
    ready_n  = ready_r;
    data_n   = data_r;
    rs_n     = rs_r;
`ifdef LCD_INIT_SEQ_EN
    init_idx_n  = init_idx;
    init_done_n = init_done;
`endif
    case (state)
      IDLE: begin
`ifdef LCD_INIT_SEQ_EN
        if (!init_done) begin
          state_n = PWRUP;
          cnt_n   = PWRUP_LD;
        end else
`endif
        if (cmd.cmd_valid && ready_r) begin
          data_n  = cmd.cmd_data;
          rs_n    = cmd.cmd_rs;
          ready_n = 1'b0;
          state_n = SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          state_n = ENABLE;
          en_n    = 1'b1;
          cnt_n   = EN_LD;
        end
      end
      ENABLE: begin
        if (cnt_last) begin
          state_n = HOLD;
          en_n    = 1'b0;
          cnt_n   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_last) begin
          state_n = WAIT;
          cnt_n   = is_long_cmd(rs_r, data_r) ? LONG_LD : EXEC_LD;
        end
      end
      WAIT: begin
        if (cnt_last) begin
`ifdef LCD_INIT_SEQ_EN
          if (!init_done && (init_idx != 3'(INIT_LEN - 1))) begin
            init_idx_n = init_idx + 3'd1;
            state_n    = INIT;
          end else begin
            init_done_n = 1'b1;
            ready_n     = 1'b1;
            state_n     = IDLE;
          end
`else
          ready_n = 1'b1;
          state_n = IDLE;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      PWRUP: begin
        if (cnt_last) begin
          state_n = INIT;
        end
      end
      // Init steps are issued as instructions through the normal write path.
      INIT: begin
        data_n  = rom_instr;
        rs_n    = 1'b0;
        state_n = SETUP;
        cnt_n   = SETUP_LD;
      end
`endif
      default: begin
        state_n = IDLE;
        en_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      en_r    <= 1'b0;
      ready_r <= READY_RST;
      data_r  <= 8'h00;
      rs_r    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      en_r    <= en_n;
      ready_r <= ready_n;
      data_r  <= data_n;
      rs_r    <= rs_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      on_r <= 1'b0;
    end else begin
      on_r <= cfg_on;
    end
  end

  assign cmd.cmd_ready = ready_r;
  assign cmd.busy      = ~ready_r;
  assign lcd_data      = data_r;
  assign lcd_rs        = rs_r;
  assign lcd_rw        = 1'b0;
  assign lcd_en        = en_r;
  assign lcd_on        = on_r;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_driver.sv
`default_nettype none
// ============================================================================
// tb_lcd_bus_driver: vector table + scoreboard of lcd_en pulses for lcd_bus_driver.
// Revision 1.0
// ============================================================================
module tb_lcd_bus_driver;

  localparam int EXEC = 40;
  localparam int LONG = 150;
  localparam int L_N  = 3 + 12 + 2 + EXEC;
  localparam int L_L  = 3 + 12 + 2 + LONG;
`ifdef LCD_INIT_SEQ_EN
  localparam logic READY_RST = 1'b0;
`else
  localparam logic READY_RST = 1'b1;
`endif

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_on = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pulses = 0;
  int rise_cyc = 0;
  int width = 0;
  logic en_q = 1'b0;
  logic [8:0] exp_pulse;
  logic [8:0] sb[$];
  vec_t vecs[8];

  lcd_bus_driver_if cmd_if();

  lcd_bus_driver #(
    .SETUP_CYC     (3),
    .EN_CYC        (12),
    .HOLD_CYC      (2),
    .EXEC_CYC      (EXEC),
    .LONG_EXEC_CYC (LONG)
`ifdef LCD_INIT_SEQ_EN
    ,
    .POWERUP_CYC   (100)
`endif
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd      (cmd_if),
    .cfg_on   (cfg_on),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_on   (lcd_on)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Each lcd_en rising edge consumes one expected {rs,data} from the scoreboard.
  always @(negedge clk) begin
    if (lcd_en && !en_q) begin
      rise_cyc = cyc;
      pulses++;
      chk("pulse_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_pulse = sb.pop_front();
        chk("pulse_rs_data", int'({lcd_rs, lcd_data}), int'(exp_pulse));
        chk("pulse_rw", int'(lcd_rw), 0);
      end
    end
    if (!lcd_en && en_q) width = cyc - rise_cyc;
    en_q = lcd_en;
  end

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    @(negedge clk);
    cmd_if.cmd_rs    = rs;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_if.cmd_ready) break;
      @(negedge clk);
    end
    chk("ready_before_accept", int'(cmd_if.cmd_ready), 1);
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_if.cmd_valid = 1'b0;
    chk("latched_data", int'(lcd_data), int'(d));
    chk("latched_rs", int'(lcd_rs), int'(rs));
    chk("ready_low_after_accept", int'(cmd_if.cmd_ready), 0);
  endtask

  task automatic wait_ready(input int acc, input int lat);
    for (int i = 0; i < lat + 100; i++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) break;
    end
    chk("ready_returned", int'(cmd_if.cmd_ready), 1);
    chk("ready_latency", cyc - acc, lat);
    chk("en_rise_offset", rise_cyc - acc, 3);
    chk("en_width", width, 12);
    chk("busy_inverse", int'(cmd_if.busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    sb.push_back({v.rs, v.data});
    send(v.rs, v.data, acc);
    wait_ready(acc, v.lat);
  endtask

  initial begin
    int acc, acc1, acc2, p0;
    vecs[0] = '{1'b1, 8'h41, L_N};
    vecs[1] = '{1'b0, 8'h01, L_L};
    vecs[2] = '{1'b0, 8'h02, L_L};
    vecs[3] = '{1'b0, 8'h03, L_L};
    vecs[4] = '{1'b0, 8'h04, L_N};
    vecs[5] = '{1'b1, 8'h01, L_N};
    vecs[6] = '{1'b0, 8'h00, L_N};
    vecs[7] = '{1'b0, 8'h05, L_N};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_rs    = 1'b0;
    cmd_if.cmd_data  = 8'h00;
    cfg_on  = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_on", int'(lcd_on), 0);
    chk("rst_ready", int'(cmd_if.cmd_ready), int'(READY_RST));
    chk("rst_busy", int'(cmd_if.busy), int'(!READY_RST));
    reset_n = 1'b1;
    @(negedge clk);
    chk("on_follows_cfg", int'(lcd_on), 1);

`ifdef LCD_INIT_SEQ_EN
    push_init();
    send(1'b1, 8'h31, acc);
    chk("init_pulses_before_accept", pulses, 6);
    wait_ready(acc, L_N);
`endif

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back: valid held across two commands, second accepted on first ready cycle.
    p0 = pulses;
    sb.push_back({1'b1, 8'h48});
    sb.push_back({1'b1, 8'h49});
    @(negedge clk);
    cmd_if.cmd_rs    = 1'b1;
    cmd_if.cmd_data  = 8'h48;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_if.cmd_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    acc1 = cyc;
    cmd_if.cmd_data = 8'h49;
    for (int i = 0; i < L_N + 100; i++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) break;
    end
    chk("b2b_ready_latency", cyc - acc1, L_N);
    @(posedge clk);
    #1;
    acc2 = cyc;
    cmd_if.cmd_valid = 1'b0;
    chk("b2b_accept_gap", acc2 - acc1, L_N + 1);
    chk("b2b_second_data", int'(lcd_data), 8'h49);
    chk("b2b_ready_low", int'(cmd_if.cmd_ready), 0);
    wait_ready(acc2, L_N);
    chk("b2b_pulse_count", pulses - p0, 2);

    // Asynchronous reset in the middle of the enable pulse.
    sb.push_back({1'b1, 8'h55});
    send(1'b1, 8'h55, acc);
    for (int i = 0; i < 20; i++) begin
      if (lcd_en) break;
      @(negedge clk);
    end
    chk("mid_en_high", int'(lcd_en), 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_en", int'(lcd_en), 0);
    chk("mid_rst_data", int'(lcd_data), 0);
    chk("mid_rst_rs", int'(lcd_rs), 0);
    chk("mid_rst_on", int'(lcd_on), 0);
    chk("mid_rst_ready", int'(cmd_if.cmd_ready), int'(READY_RST));
    @(negedge clk);
    reset_n = 1'b1;
`ifdef LCD_INIT_SEQ_EN
    push_init();
`endif
    run_vec('{1'b1, 8'h5A, L_N});

    // cfg_on toggling while a command is in flight.
    sb.push_back({1'b1, 8'h60});
    send(1'b1, 8'h60, acc);
    @(negedge clk);
    cfg_on = 1'b0;
    #1 chk("on_not_yet", int'(lcd_on), 1);
    @(negedge clk);
    chk("on_fell", int'(lcd_on), 0);
    cfg_on = 1'b1;
    @(negedge clk);
    chk("on_rose", int'(lcd_on), 1);
    wait_ready(acc, L_N);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Hardware timing engine for the HD44780-compatible character LCD.
- Sits directly downstream of the 12-bit LCD output register, in place of software bit-banging. Software writes a byte plus RS; the block generates the setup, enable-pulse, hold and execution-wait timing on the LCD pins.
- Its 12 pin outputs are lcd_data[7:0], lcd_rs, lcd_rw, lcd_en and lcd_on. They map one-to-one onto the existing 12-bit pin bundle.

Parameters:
- SETUP_CYC, 3: cycles lcd_data/lcd_rs are stable before lcd_en rises. Must be ≥1.
- EN_CYC, 12: lcd_en high width in cycles (240 ns at 50 MHz). Must be ≥1.
- HOLD_CYC, 2: cycles after lcd_en falls with lcd_data/lcd_rs held. Must be ≥1.
- EXEC_CYC, 2000: execution wait for normal commands and data (40 us at 50 MHz). Must be ≥1.
- LONG_EXEC_CYC, 82000: execution wait for clear/home (1.64 ms at 50 MHz). Must be ≥1.
- POWERUP_CYC, 750000: power-up delay before the init sequence (15 ms). Used only with LCD_INIT_SEQ_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  block can accept a request this cycle.
- cmd_rs  in  1  0 = instruction, 1 = data.
- cmd_data  in  8  instruction/data byte.
- cfg_on  in  1  LCD power enable, level input.
- busy  out  1  equals ~cmd_ready.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  read/write; constant 0, write only.
- lcd_en  out  1  enable strobe.
- lcd_on  out  1  registered copy of cfg_on.

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk. All flops are cleared asynchronously.
- Reset values:
  - lcd_data = 0, lcd_rs = 0, lcd_rw = 0, lcd_en = 0, lcd_on = 0.
  - State = IDLE.
  - cmd_ready = 1 (0 with LCD_INIT_SEQ_EN).
- lcd_on follows cfg_on with one cycle of latency.
- Handshake:
  - Transfer occurs on a rising edge where cmd_valid && cmd_ready.
  - cmd_ready is registered and is 1 only in IDLE.
  - cmd_valid while cmd_ready = 0 is ignored. The requester holds its request until accepted.
- States: IDLE -> SETUP -> ENABLE -> HOLD -> WAIT -> IDLE. One down-counter (20 bits) is reloaded on each state entry.
  - IDLE: on transfer, latch cmd_data/cmd_rs into lcd_data/lcd_rs, go to SETUP, and deassert cmd_ready in the same edge.
  - SETUP: SETUP_CYC cycles, lcd_en = 0.
  - ENABLE: exactly EN_CYC cycles with lcd_en = 1. lcd_en is registered and glitch-free.
  - HOLD: HOLD_CYC cycles, lcd_en = 0, lcd_data/lcd_rs unchanged.
  - WAIT: LONG_EXEC_CYC if the latched rs == 0 && data[7:2] == 0 && data[1:0] != 0 (clear 0x01, home 0x02/0x03); otherwise EXEC_CYC. On exit, cmd_ready = 1.
- Latency and throughput:
  - Accept edge to cmd_ready high = SETUP_CYC + EN_CYC + HOLD_CYC + WAIT_CYC cycles.
  - A new request may transfer on the first cycle cmd_ready is high, so back-to-back requests have no extra gap.
- lcd_data/lcd_rs keep the last value in IDLE and change only on a transfer edge.
- Reset mid-operation: lcd_en drops to 0 immediately and asynchronously, the pending command is discarded, and all outputs return to their reset values.
- cfg_on changes never disturb the FSM.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- Defined:
  - After reset, wait POWERUP_CYC cycles.
  - Then autonomously issue instructions 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 through the same SETUP..WAIT path.
  - cmd_ready stays 0 until the final WAIT completes. External requests during init are not accepted.
  - The 0x01 step uses LONG_EXEC_CYC.
- Undefined:
  - No init logic is present and cmd_ready = 1 from reset.
  - Software performs LCD initialisation.

Decomposition:
- Package lcd_pkg holds:
  - the state encoding (IDLE, SETUP, ENABLE, HOLD, WAIT, plus PWRUP and INIT when the feature is enabled);
  - CNT_W = 20;
  - instruction constants LCD_FUNC_SET = 8'h38, LCD_DISP_ON = 8'h0C, LCD_CLEAR = 8'h01, LCD_ENTRY = 8'h06;
  - INIT_LEN = 6.
- Sub-module lcd_init_rom: a 3-bit index to 8-bit instruction lookup. It is instantiated only under LCD_INIT_SEQ_EN.

Test Plan:
- Reset, then transfer rs = 1, data = 0x41:
  - lcd_data = 0x41 and lcd_rs = 1 on the next cycle;
  - lcd_en rises 3 cycles later and stays high exactly 12 cycles;
  - cmd_ready returns 2017 cycles after the accept edge.
- Transfer rs = 0, data = 0x01 -> cmd_ready returns after 3+12+2+82000 = 82017 cycles. Repeat with data 0x02 (same wait) and 0x04 (2017 cycles).
- Hold cmd_valid high with two queued commands 0x48/0x49 -> second transfer on the first ready-high cycle; zero idle gap; exactly two lcd_en pulses.
- Assert reset_n = 0 mid-ENABLE -> lcd_en = 0 within the same cycle, all outputs 0; after release a new request completes normally.
- With LCD_INIT_SEQ_EN and POWERUP_CYC = 100 in the bench -> six lcd_en pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with lcd_rs = 0; cmd_valid asserted during init is not accepted until the final wait ends.
- Toggle cfg_on mid-command -> lcd_on follows with 1-cycle latency; the command timing is unchanged.
